// File: rtl/store_unit_if.sv
// Execute-stage store handshake plus data-memory write port for store_unit.
// The master modport is the store unit; slave is the execute stage / memory side.
interface store_unit_if;
  logic        st_valid_in;
  logic        st_ready_out;
  logic [31:0] iadder_in;
  logic [31:0] rs2_in;
  logic [1:0]  store_size_in;
  logic        dmwr_req_out;
  logic [31:0] dmaddr_out;
  logic [31:0] dmdata_out;
  logic [3:0]  wr_mask_out;
  logic        dmwr_ack_in;
  logic        st_done_out;
  logic        bus_err_out;
  logic        misaligned_out;

  modport master (
    input  st_valid_in, iadder_in, rs2_in, store_size_in, dmwr_ack_in,
    output st_ready_out, dmwr_req_out, dmaddr_out, dmdata_out, wr_mask_out,
           st_done_out, bus_err_out, misaligned_out
  );

  modport slave (
    output st_valid_in, iadder_in, rs2_in, store_size_in, dmwr_ack_in,
    input  st_ready_out, dmwr_req_out, dmaddr_out, dmdata_out, wr_mask_out,
           st_done_out, bus_err_out, misaligned_out
  );
endinterface

// File: rtl/store_unit.sv
// Store unit: lane-aligns store data, issues one outstanding write with ack timeout.
// Optional STORE_MISALIGN_TRAP_EN: misaligned half/word stores trap instead of force-aligning.
module store_unit #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  store_unit_if.master bus
);

  typedef enum logic {IDLE, REQ} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        mask_q, mask_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              trap;

  logic [1:0]        a;
  logic [31:0]       fmt_data;
  logic [3:0]        fmt_mask;
  logic              accept;

  assign bus.st_ready_out = (state_q == IDLE) & ~rst_in;
  assign accept           = bus.st_valid_in & bus.st_ready_out;
  assign a                = bus.iadder_in[1:0];

  always_comb begin
    fmt_data = bus.rs2_in;
    fmt_mask = 4'b1111;
    case (bus.store_size_in)
      2'b00: begin
        fmt_data = {4{bus.rs2_in[7:0]}};
        fmt_mask = 4'b0001 << a;
      end
      2'b01: begin
        fmt_data = {2{bus.rs2_in[15:0]}};
        fmt_mask = a[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        fmt_data = bus.rs2_in;
        fmt_mask = 4'b1111;
      end
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  always_comb begin
    case (bus.store_size_in)
      2'b00:   trap = 1'b0;
      2'b01:   trap = a[0];
      default: trap = (a != 2'b00);
    endcase
  end

  assign mis_d              = (state_q == IDLE) & accept & trap;
  assign bus.misaligned_out = mis_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
`else
  assign trap               = 1'b0;
  assign bus.misaligned_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (trap) begin
            done_d = 1'b1;
          end else begin
            addr_d  = {bus.iadder_in[31:2], 2'b00};
            data_d  = fmt_data;
            mask_d  = fmt_mask;
            cnt_d   = '0;
            req_d   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // Ack takes priority over an expiry in the same cycle.
        if (bus.dmwr_ack_in) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (ACK_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (ACK_TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.dmwr_req_out = req_q;
  assign bus.dmaddr_out   = addr_q;
  assign bus.dmdata_out   = data_q;
  assign bus.wr_mask_out  = mask_q;
  assign bus.st_done_out  = done_q;
  assign bus.bus_err_out  = err_q;

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side counterpart of the load path.
- Accepts one store from the execute stage per handshake and aligns rs2 data into the correct byte lanes. Generates a 4-bit byte write mask and drives a single-outstanding write request to data memory until it is acknowledged.
- Includes an acknowledge timeout that reports a bus error instead of hanging the pipeline.

Parameters:
- ACK_TIMEOUT, 16, cycles to wait in REQ for dmwr_ack_in before aborting with bus_err_out; 0 disables the timeout (wait forever).
- CNT_W, 8, width of the timeout counter; must satisfy ACK_TIMEOUT < 2^CNT_W.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- rst_in  input  1  synchronous active-high reset.
- st_valid_in  input  1  store request from execute stage.
- st_ready_out  output  1  unit can accept a store this cycle.
- iadder_in  input  32  effective byte address.
- rs2_in  input  32  store data, LSB-aligned.
- store_size_in  input  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 treated as word.
- dmwr_req_out  output  1  write request to data memory.
- dmaddr_out  output  32  word-aligned address, {addr[31:2],2'b00}.
- dmdata_out  output  32  lane-replicated write data.
- wr_mask_out  output  4  byte enables; bit i enables byte lane i (bits 8i+7:8i).
- dmwr_ack_in  input  1  memory accepted write.
- st_done_out  output  1  one-cycle pulse: store retired (success or error).
- bus_err_out  output  1  one-cycle pulse coincident with st_done_out on timeout.
- misaligned_out  output  1  one-cycle misalignment pulse; constant 0 without STORE_MISALIGN_TRAP_EN.

Behaviour:
- Reset (rst_in=1 at an edge): state=IDLE, counter=0. All registered outputs clear to 0: dmwr_req_out, dmaddr_out, dmdata_out, wr_mask_out, st_done_out, bus_err_out, misaligned_out.
- st_ready_out = (state==IDLE) & ~rst_in.
- Reset mid-transaction drops dmwr_req_out at that edge. A later dmwr_ack_in is ignored.
- Lane formatting, computed at accept using a = iadder_in[1:0]:
  - byte: data={4{rs2[7:0]}}, mask=4'b0001<<a.
  - half: data={2{rs2[15:0]}}, mask=a[1]?4'b1100:4'b0011; a[0] is ignored.
  - word/11: data=rs2, mask=4'b1111; a is ignored.
- States:
  - IDLE: on st_valid_in & st_ready_out at edge N, capture formatted addr/data/mask, clear counter, go REQ. dmwr_req_out=1 from cycle N+1.
  - REQ: dmwr_req_out, dmaddr_out, dmdata_out and wr_mask_out are held stable.
    - dmwr_ack_in=1 in any REQ cycle, including the first: at that edge drop req, pulse st_done_out next cycle, go IDLE.
    - Best case: accept N, ack N+1, done and ready at N+2. Back-to-back stores are accepted every 2 cycles.
  - Timeout (ACK_TIMEOUT>0): counter increments each REQ cycle without ack. In the cycle the counter equals ACK_TIMEOUT-1 with no ack: drop req, pulse st_done_out and bus_err_out next cycle, go IDLE.
  - Ack in the same cycle as expiry: ack wins, no bus_err_out.
- dmwr_ack_in while IDLE is ignored.
- st_valid_in while not ready is ignored; the upstream stage holds the request.
- Data, address and mask registers keep their last value after completion. Only dmwr_req_out qualifies them.

Optional Feature:
- Macro STORE_MISALIGN_TRAP_EN.
- Defined:
  - Half with a[0]=1, or word/11 with a!=0, raises no bus request. The unit stays in IDLE.
  - st_done_out and misaligned_out pulse in cycle N+1.
  - Accept is still consumed.
- Undefined: misaligned stores are silently force-aligned per the lane rules above; misaligned_out is tied 0.

Test Plan:
- Byte store: iadder=0x1003, rs2=0x000000A5, size=00, ack in first REQ cycle -> dmaddr=0x1000, dmdata=0xA5A5A5A5, mask=1000, req high 1 cycle, st_done at N+2, bus_err=0.
- Half store: iadder=0x2002, rs2=0x1234BEEF, size=01, ack after 3 REQ cycles -> dmdata=0xBEEFBEEF, mask=1100, outputs stable all 3 cycles, single done pulse.
- Timeout: ACK_TIMEOUT=4, no ack -> req high exactly 4 cycles, then st_done=1 and bus_err=1 for one cycle, ready returns; variant with ack on 4th cycle -> bus_err=0.
- Misaligned word: iadder=0x3001, size=10 -> with STORE_MISALIGN_TRAP_EN: no req, misaligned=1 and done=1 at N+1; without it: dmaddr=0x3000, mask=1111, normal write.
- Reset mid-REQ: assert rst_in one cycle during REQ, then ack -> req=0 after the reset edge, no st_done, st_ready=1 on the first cycle after reset release; next store completes normally.
